// File: rtl/stream_demux_reg.sv
// -----------------------------------------------------------------------------
// stream_demux_reg
//
// Registered 1-to-N stream demultiplexer. Each beat of a single valid/ready
// input stream is routed to the output channel named by its per-beat select.
// Every output channel owns a 1-deep holding register, so out_valid and
// out_data come straight from flops. Beats whose select names a channel that
// does not exist are swallowed and counted in a saturating drop counter.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous, active-low reset
//   in_valid    input beat present
//   in_ready    input beat accepted this cycle when high with in_valid
//   in_data     input payload (WIDTH bits)
//   in_sel      destination channel index (SEL_W bits)
//   out_valid   bit i: channel i holds a beat
//   out_ready   bit i: consumer of channel i takes the beat
//   out_data    channel i payload on bits [i*WIDTH +: WIDTH]
//   drop_count  saturating count of beats discarded for an out-of-range select
// -----------------------------------------------------------------------------
module stream_demux_reg #(
  parameter  int WIDTH = 8,
  parameter  int N_OUT = 4,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [7:0]             drop_count
);

  // N_OUT held one bit wider than the select so a non-power-of-two channel
  // count still compares correctly against every select value.
  localparam logic [SEL_W:0] NOutW = (SEL_W+1)'(N_OUT);

  logic [N_OUT-1:0]            valid_q, valid_d;
  logic [N_OUT-1:0][WIDTH-1:0] data_q,  data_d;
  logic [7:0]                  drop_q,  drop_d;

  logic             sel_ok;
  logic             dest_free;
  logic             accept;
  logic [N_OUT-1:0] pop;
  logic [N_OUT-1:0] load;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    dest_free = 1'b0;
    load      = '0;
    valid_d   = valid_q;
    data_d    = data_q;
    drop_d    = drop_q;

    sel_ok = {1'b0, in_sel} < NOutW;

    // Select the destination by comparison rather than by indexing, so an
    // out-of-range select never reads past the end of valid_q.
    for (int i = 0; i < N_OUT; i++) begin
      if (in_sel == SEL_W'(i)) dest_free = !valid_q[i] || out_ready[i];
    end

    // Out-of-range beats are always taken (and dropped) so they cannot wedge
    // the input stream. in_ready never looks at in_valid.
    in_ready = sel_ok ? dest_free : 1'b1;
    accept   = in_valid && in_ready;
    pop      = valid_q & out_ready;

    for (int i = 0; i < N_OUT; i++) begin
      load[i] = accept && sel_ok && (in_sel == SEL_W'(i));
      // A load overrides a same-cycle pop: the slot stays full with new data,
      // which is what gives each channel one beat per cycle.
      valid_d[i] = load[i] || (valid_q[i] && !pop[i]);
      if (load[i]) data_d[i] = in_data;
    end

    if (accept && !sel_ok && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their next-state values from the same edge without ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      // NOTE: the payload registers are reset too, because out_data is
      // visible directly from these flops and must read zero during reset.
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_stream_demux_reg.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_reg
//
// Scoreboard bench for stream_demux_reg with N_OUT=3, WIDTH=8. The stimulus
// side pushes each beat it expects to be accepted into a per-channel queue;
// a monitor running on the falling edge pops and compares whenever a channel
// presents a beat that its consumer takes. Directed checks cover reset,
// in_ready, latency, saturation and stall stability.
// -----------------------------------------------------------------------------
module tb_stream_demux_reg;

  localparam int WIDTH = 8;
  localparam int N_OUT = 3;
  localparam int SEL_W = 2;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [7:0]             drop_count;

  int errors = 0;
  int checks = 0;
  int exp_drop = 0;

  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];
  logic [WIDTH-1:0] exp_q2[$];

  stream_demux_reg #(.WIDTH(WIDTH), .N_OUT(N_OUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] slice(input int i);
    return out_data[i*WIDTH +: WIDTH];
  endfunction

  task automatic push_exp(input int ch, input logic [WIDTH-1:0] d);
    case (ch)
      0: exp_q0.push_back(d);
      1: exp_q1.push_back(d);
      default: exp_q2.push_back(d);
    endcase
  endtask

  // One cycle of stimulus, entered and left at posedge+1. Inputs stay driven
  // afterwards until the next call or an explicit change.
  task automatic drive_beat(input logic v, input logic [SEL_W-1:0] sel,
                            input logic [WIDTH-1:0] d, input logic [N_OUT-1:0] rdy,
                            input logic exp_rdy);
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = rdy;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (v && exp_rdy) begin
      if (int'(sel) < N_OUT) push_exp(int'(sel), d);
      else if (exp_drop < 255) exp_drop++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [N_OUT-1:0] rdy);
    in_valid  = 1'b0;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Look at in_ready for a select without offering a beat.
  task automatic probe(input logic [SEL_W-1:0] sel, input logic [N_OUT-1:0] rdy,
                       input logic exp_rdy, input string name);
    in_valid  = 1'b0;
    in_sel    = sel;
    out_ready = rdy;
    #1;
    check(name, {31'd0, in_ready}, {31'd0, exp_rdy});
  endtask

  // Monitor: a beat taken by the consumer must be the oldest one sent there.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          logic [WIDTH-1:0] e;
          int sz;
          sz = (i == 0) ? exp_q0.size() : (i == 1) ? exp_q1.size() : exp_q2.size();
          if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop ch%0d: got %0h expected no beat", i, slice(i));
          end else begin
            e = (i == 0) ? exp_q0.pop_front() : (i == 1) ? exp_q1.pop_front() : exp_q2.pop_front();
            check($sformatf("pop_data_ch%0d", i), {24'd0, slice(i)}, {24'd0, e});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;
    #1;
    check("reset_out_valid",  {29'd0, out_valid}, 32'd0);
    check("reset_out_data",   {8'd0, out_data},   32'd0);
    check("reset_drop_count", {24'd0, drop_count}, 32'd0);
    check("reset_in_ready",   {31'd0, in_ready},  32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single beat to channel 1, held with no consumer.
    drive_beat(1'b1, 2'd1, 8'hA5, 3'b000, 1'b1);
    in_valid = 1'b0;
    check("s1_out_valid", {29'd0, out_valid}, 32'b010);
    check("s1_slice1",    {24'd0, slice(1)},  32'hA5);
    probe(2'd1, 3'b000, 1'b0, "s1_ready_full_ch1");
    probe(2'd0, 3'b000, 1'b1, "s1_ready_empty_ch0");

    // 2: pop and load on channel 1 in one cycle, no bubble.
    drive_beat(1'b1, 2'd1, 8'h5A, 3'b010, 1'b1);
    in_valid = 1'b0;
    check("s2_out_valid", {29'd0, out_valid}, 32'b010);
    check("s2_slice1",    {24'd0, slice(1)},  32'h5A);
    idle(3'b111);
    check("s2_drained", {29'd0, out_valid}, 32'd0);

    // 3: round-robin stream at full rate.
    for (int k = 0; k < 9; k++) begin
      drive_beat(1'b1, SEL_W'(k % 3), 8'(k), 3'b111, 1'b1);
      check($sformatf("s3_valid_beat%0d", k), {31'd0, out_valid[k % 3]}, 32'd1);
      check($sformatf("s3_data_beat%0d", k),  {24'd0, slice(k % 3)},     32'(k));
    end
    idle(3'b111);
    check("s3_drained", {29'd0, out_valid}, 32'd0);

    // 4: out-of-range select is always accepted, dropped and counted.
    for (int k = 0; k < 300; k++) begin
      drive_beat(1'b1, 2'd3, 8'(k), 3'b000, 1'b1);
      if (k == 254) check("s4_drop_at_255", {24'd0, drop_count}, 32'd255);
    end
    in_valid = 1'b0;
    check("s4_drop_sat",  {24'd0, drop_count}, exp_drop);
    check("s4_out_valid", {29'd0, out_valid},  32'd0);

    // 5: asynchronous reset with channels 0 and 2 full.
    drive_beat(1'b1, 2'd0, 8'h33, 3'b000, 1'b1);
    drive_beat(1'b1, 2'd2, 8'h44, 3'b000, 1'b1);
    in_valid = 1'b0;
    check("s5_full", {29'd0, out_valid}, 32'b101);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_rst_out_valid", {29'd0, out_valid},  32'd0);
    check("s5_rst_drop",      {24'd0, drop_count}, 32'd0);
    check("s5_rst_out_data",  {8'd0, out_data},    32'd0);
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    exp_drop = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_beat(1'b1, 2'd0, 8'h11, 3'b000, 1'b1);
    check("s5_post_valid", {29'd0, out_valid}, 32'b001);
    check("s5_post_data",  {24'd0, slice(0)},  32'h11);

    // 6: stalled beat behind a full channel 0, then pop and load together.
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 8'h77;
    out_ready = 3'b000;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("s6_stall_ready%0d", k), {31'd0, in_ready},     32'd0);
      check($sformatf("s6_stall_valid%0d", k), {31'd0, out_valid[0]}, 32'd1);
      check($sformatf("s6_stall_data%0d", k),  {24'd0, slice(0)},     32'h11);
      @(posedge clk);
      #1;
    end
    drive_beat(1'b1, 2'd0, 8'h77, 3'b001, 1'b1);
    in_valid = 1'b0;
    check("s6_new_valid", {31'd0, out_valid[0]}, 32'd1);
    check("s6_new_data",  {24'd0, slice(0)},     32'h77);
    idle(3'b111);
    idle(3'b000);

    check("end_q0_empty", exp_q0.size(), 32'd0);
    check("end_q1_empty", exp_q1.size(), 32'd0);
    check("end_q2_empty", exp_q2.size(), 32'd0);
    check("end_out_valid", {29'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
